// File: rtl/cpu_isa_pkg.sv
// ISA constants shared by the program encoder and the instruction decoder:
// register IDs, opcode prefixes, command classes and encoder states.
package cpu_isa_pkg;

  // Register IDs; the result register R and the output port O share ID 4
  localparam logic [2:0] REG_X0 = 3'd0;
  localparam logic [2:0] REG_X1 = 3'd1;
  localparam logic [2:0] REG_Y0 = 3'd2;
  localparam logic [2:0] REG_Y1 = 3'd3;
  localparam logic [2:0] REG_R  = 3'd4;
  localparam logic [2:0] REG_O  = 3'd4;
  localparam logic [2:0] REG_DM = 3'd7;

  localparam logic       OP_LOAD  = 1'b0;
  localparam logic [1:0] OP_MOVE  = 2'b10;
  localparam logic [2:0] OP_ALU   = 3'b110;
  localparam logic [3:0] OP_JUMP  = 4'b1110;
  localparam logic [3:0] OP_CJUMP = 4'b1111;
  localparam logic [7:0] NOP_WORD = 8'hC8;

  typedef enum logic [2:0] {
    CLS_LOAD  = 3'd0,
    CLS_MOVE  = 3'd1,
    CLS_ALU   = 3'd2,
    CLS_JUMP  = 3'd3,
    CLS_CJUMP = 3'd4,
    CLS_NOP   = 3'd5
  } cmd_class_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_WRITE,
    ST_HALT,
    ST_DONE
  } enc_state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: symbolic command -> 8-bit instruction word.
// Classes 6 and 7 raise illegal and produce a zero word.
module instr_pack
  import cpu_isa_pkg::*;
(
  input  logic [2:0] cmd_class,
  input  logic [2:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic [7:0] word,
  output logic       illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (cmd_class)
      CLS_LOAD:  word = {OP_LOAD, cmd_a, cmd_b};
      // dst == src == 4 is a legal R->O move and is packed unchanged
      CLS_MOVE:  word = {OP_MOVE, cmd_a, cmd_b[2:0]};
      CLS_ALU:   word = {OP_ALU, cmd_a[2], cmd_a[1], cmd_b[2:0]};
      CLS_JUMP:  word = {OP_JUMP, cmd_b};
      CLS_CJUMP: word = {OP_CJUMP, cmd_b};
      CLS_NOP:   word = NOP_WORD;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// On-chip program assembler: accepts commands, packs them and writes PM sequentially.
// Define ENC_HALT_EN to append a JUMP-to-self halt word after the last command.
module instr_encoder
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              sync_reset,
  input  logic              start,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_class,
  input  logic [2:0]        cmd_a,
  input  logic [3:0]        cmd_b,
  input  logic              cmd_last,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [7:0]        pm_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   instr_count
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  enc_state_e        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        wdata_reg, wdata_next;
  logic              last_reg, last_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic [ADDR_W:0]   count_reg, count_next;

  logic [7:0]        pack_word;
  logic              pack_illegal;
  logic [ADDR_W-1:0] addr_inc;

  instr_pack u_pack (
    .cmd_class (cmd_class),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .word      (pack_word),
    .illegal   (pack_illegal)
  );

  assign addr_inc = addr_reg + 1'b1;

`ifdef ENC_HALT_EN
  // Jump targets are nibbles; narrower address spaces are zero-extended
  logic [3:0] halt_tgt;
  for (genvar gi = 0; gi < 4; gi++) begin : g_tgt
    if (gi < ADDR_W) begin : g_bit
      assign halt_tgt[gi] = addr_inc[gi];
    end else begin : g_zero
      assign halt_tgt[gi] = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_reg <= ST_IDLE;
      addr_reg  <= BASE;
      wdata_reg <= '0;
      last_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      last_reg  <= last_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    last_next  = last_reg;
    done_next  = done_reg;
    err_next   = err_reg;
    count_next = count_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = ST_ACCEPT;
          addr_next  = BASE;
          count_next = '0;
          err_next   = 1'b0;
          done_next  = 1'b0;
        end
      end
      ST_ACCEPT: begin
        if (cmd_valid) begin
          if (pack_illegal) begin
            err_next   = 1'b1;
            done_next  = 1'b1;
            state_next = ST_DONE;
          end else begin
            wdata_next = pack_word;
            last_next  = cmd_last;
            state_next = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        addr_next  = addr_inc;
        count_next = count_reg + 1'b1;
        state_next = ST_DONE;
        done_next  = 1'b1;
        if (last_reg) begin
`ifdef ENC_HALT_EN
          if (addr_reg == LAST_ADDR) begin
            err_next = 1'b1;
          end else begin
            wdata_next = {OP_JUMP, halt_tgt};
            state_next = ST_HALT;
            done_next  = 1'b0;
          end
`endif
        end else if (addr_reg == LAST_ADDR) begin
          err_next = 1'b1;
        end else begin
          state_next = ST_ACCEPT;
          done_next  = 1'b0;
        end
      end
      ST_HALT: begin
        addr_next  = addr_inc;
        count_next = count_reg + 1'b1;
        done_next  = 1'b1;
        state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Write strobe is masked by reset so an abort never lets a write through
  assign pm_we       = ((state_reg == ST_WRITE) || (state_reg == ST_HALT)) && !sync_reset;
  assign cmd_ready   = (state_reg == ST_ACCEPT);
  assign busy        = (state_reg == ST_ACCEPT) || (state_reg == ST_WRITE) ||
                       (state_reg == ST_HALT);
  assign pm_addr     = addr_reg;
  assign pm_wdata    = wdata_reg;
  assign done        = done_reg;
  assign err         = err_reg;
  assign instr_count = count_reg;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- On-chip program assembler for the 8-bit CPU.
- Accepts symbolic instruction commands over a valid/ready handshake and packs each into the 8-bit ISA format that the instruction decoder consumes.
- Writes encoded words sequentially into program memory through its write port.
- Used by the boot/test loader to build programs in PM before the core is released from reset.

Parameters:
- ADDR_W, 4, program-memory address width. Jump targets are 4-bit nibbles, so ADDR_W > 4 means jumps reach only the low 16 words.
- BASE_ADDR, 0, first PM address written after start.

Ports:
- clk  input  1  system clock
- sync_reset  input  1  synchronous active-high reset
- start  input  1  begin a new program at BASE_ADDR; honoured only in IDLE or DONE
- cmd_valid  input  1  command present
- cmd_ready  output  1  encoder can accept a command
- cmd_class  input  3  0 LOAD, 1 MOVE, 2 ALU, 3 JUMP, 4 CJUMP, 5 NOP, 6-7 illegal
- cmd_a  input  3  LOAD/MOVE dst; ALU {x_sel,y_sel,-}
- cmd_b  input  4  LOAD data; MOVE src in [2:0]; ALU func in [2:0]; JUMP/CJUMP target
- cmd_last  input  1  final command of the program
- pm_we  output  1  program-memory write strobe
- pm_addr  output  ADDR_W  write address
- pm_wdata  output  8  encoded instruction
- busy  output  1  high in ACCEPT/WRITE/HALT
- done  output  1  program complete; held until start or reset
- err  output  1  sticky error (illegal class or PM overflow); cleared by start
- instr_count  output  ADDR_W+1  number of words written this program

Behaviour:
- Reset values: cmd_ready=0, pm_we=0, pm_addr=BASE_ADDR, pm_wdata=0, busy=0, done=0, err=0, instr_count=0, state=IDLE.
- Reset mid-operation aborts immediately with no further writes.
- Encoding:
  - LOAD = {0, a[2:0], b[3:0]}
  - MOVE = {10, a[2:0], b[2:0]}
  - ALU = {110, a[2], a[1], b[2:0]}
  - JUMP = {1110, b}
  - CJUMP = {1111, b}
  - NOP = 8'hC8
  - MOVE with dst=src=4 encodes as-is (r->o); no rewriting.
- States: IDLE, ACCEPT, WRITE, HALT, DONE.
- IDLE/DONE: on start, go to ACCEPT; pm_addr=BASE_ADDR, instr_count=0, err=0, done=0.
- ACCEPT: cmd_ready=1. On cmd_valid && cmd_ready:
  - Legal class: latch the encoded word into pm_wdata and the cmd_last flag, then go to WRITE.
  - Illegal class: set err, go to DONE, no write.
- WRITE: cmd_ready=0, pm_we=1 for exactly one cycle. The command accepted in cycle N is written in cycle N+1; throughput is one command per 2 cycles. Next cycle: pm_addr+1, instr_count+1, then:
  - If last: go to HALT (feature on) or DONE.
  - Else if pm_addr was 2**ADDR_W-1: set err, go to DONE (no wrap).
  - Else go to ACCEPT.
- HALT: see Optional Feature.
- start while busy is ignored. cmd_valid outside ACCEPT is ignored and not consumed.
- done and err remain stable until the next start or reset.

Optional Feature:
- Macro ENC_HALT_EN.
- Defined:
  - After the last command's WRITE, the HALT state writes JUMP-to-self {1110, pm_addr[3:0]} at the next address.
  - pm_we is high for 1 cycle, instr_count increments, then DONE.
  - If the last command occupied 2**ADDR_W-1, the halt word is not written; err is set and the block goes to DONE.
- Undefined: HALT state is absent; last WRITE goes straight to DONE.

Decomposition:
- Package cpu_isa_pkg:
  - Register IDs (X0=0 … DM=7, O shares 4 with R).
  - Opcode prefixes (LOAD 1'b0, MOVE 2'b10, ALU 3'b110, JUMP 4'b1110, CJUMP 4'b1111) and NOP constant 8'hC8.
  - cmd_class enum; encoder state enum.
  - Shared with the instruction decoder.
- Sub-module instr_pack: purely combinational {cmd_class, cmd_a, cmd_b} -> {word[7:0], illegal}. The top holds the FSM, address counter and count.

Test Plan:
- start; LOAD a=0 b=5, then MOVE a=4 b=4 with last -> pm_we pulses write 8'h05@0 and 8'hA4@1; done=1; instr_count=2; err=0.
- ALU a=3'b100 b=3; JUMP b=4'hA; CJUMP b=3 with last -> writes 8'hD3, 8'hEA, 8'hF3 at 0,1,2; each pm_we exactly 1 cycle after its handshake.
- cmd_class=6 as the 2nd command -> word 0 written only; err=1; done=1; no pm_we after the illegal accept; next start clears err.
- 17 non-last NOPs with ADDR_W=4 -> 16 writes of 8'hC8 at 0..15, then err=1, done=1, instr_count=16, 17th command not consumed.
- ENC_HALT_EN, 3 commands, last=1 on the 3rd -> extra write 8'hE3@3; instr_count=4.
- sync_reset asserted the cycle after a handshake -> no pm_we in that cycle; all outputs return to reset values.
